// File: rtl/sprite_draw_ctrl.sv
// sprite_draw_ctrl
//
// Purpose:
//   Overlays up to NSLOT fixed-size sprites on a background video stream.
//   Software writes sprite objects into a shadow table at any time; the
//   whole shadow table is copied into the active table once per frame, at
//   the last pixel of the frame (DrawX=799, DrawY=524). Because of this,
//   a frame is always drawn from one consistent snapshot. The active
//   table is hit-tested against the current pixel. The winning slot
//   drives a sprite ROM address. The ROM's palette index then selects
//   between the palette colour and the background.
//
// Pipeline (pixel coordinate presented in the cycle ending at edge N+1):
//   edge N+1 : rom_addr, hit, blank, bg registered            (stage 1)
//   edge N+2 : external ROM samples rom_addr; hit/blank/bg delayed
//              a second time                                  (stage 2)
//   edge N+3 : red/green/blue registered from rom_q/pal_*/bg  (stage 3)
//   The latency is a constant 3 cycles whether or not a sprite hits.
//
// Ports:
//   vga_clk                      sole clock, rising edge
//   Reset                        asynchronous, active-high
//   DrawX, DrawY [9:0]           current pixel coordinate (800x525 timing)
//   blank                        1 = visible region, 0 = blanking
//   bg_red/green/blue [3:0]      background colour of the current pixel
//   wr_en                        single-cycle object write strobe
//   wr_slot [1:0]                target slot of the write
//   wr_x, wr_y [9:0]             sprite top-left corner
//   wr_type [1:0]                sprite image select
//   wr_valid                     1 = slot drawn, 0 = slot disabled
//   commit_pending               shadow table holds uncommitted writes
//   rom_addr [11:0]              {type, row[4:0], col[4:0]} to sprite ROM
//   rom_q [7:0]                  palette index from ROM, 0 = transparent
//   pal_red/green/blue [3:0]     combinational palette colour of rom_q
//   red, green, blue [3:0]       registered output pixel colour

module sprite_draw_ctrl #(
  parameter int NSLOT   = 4,
  parameter int SPR_DIM = 32
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic [3:0]  bg_red,
  input  logic [3:0]  bg_green,
  input  logic [3:0]  bg_blue,
  input  logic        wr_en,
  input  logic [1:0]  wr_slot,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [1:0]  wr_type,
  input  logic        wr_valid,
  output logic        commit_pending,
  output logic [11:0] rom_addr,
  input  logic [7:0]  rom_q,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  // One sprite object: top-left corner, image select and enable.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] kind;
    logic       valid;
  } obj_t;

  localparam logic [10:0] DIM = 11'(SPR_DIM);

  obj_t shadow_tbl [NSLOT];
  obj_t active_tbl [NSLOT];

  // The last pixel of the frame: the active table is swapped here so the
  // next frame starts from a fresh snapshot.
  logic commit;
  assign commit = (DrawX == 10'd799) && (DrawY == 10'd524);

  // ------------------------------------------------------------------
  // Object tables.
  // In the commit cycle the active table takes the pre-write shadow
  // contents (non-blocking semantics), while a simultaneous write lands
  // only in the shadow table and keeps commit_pending set.
  // ------------------------------------------------------------------
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        shadow_tbl[i] <= '0;
        active_tbl[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (commit) begin
        for (int i = 0; i < NSLOT; i++) begin
          active_tbl[i] <= shadow_tbl[i];
        end
      end
      if (wr_en) begin
        shadow_tbl[wr_slot] <= '{x: wr_x, y: wr_y, kind: wr_type, valid: wr_valid};
      end
      if (wr_en) begin
        commit_pending <= 1'b1;
      end else if (commit) begin
        commit_pending <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Hit test. Bounds are compared in 11 bits so that a sprite near the
  // right/bottom edge (x+SPR_DIM > 1023) is clipped rather than wrapping
  // around to column/row 0.
  // ------------------------------------------------------------------
  logic [NSLOT-1:0] hit_vec;
  logic [11:0]      addr_vec [NSLOT];

  always_comb begin
    logic [10:0] px, py, x_lo, y_lo;
    logic [4:0]  dx, dy;
    hit_vec = '0;
    for (int i = 0; i < NSLOT; i++) begin
      px   = {1'b0, DrawX};
      py   = {1'b0, DrawY};
      x_lo = {1'b0, active_tbl[i].x};
      y_lo = {1'b0, active_tbl[i].y};
      hit_vec[i] = active_tbl[i].valid &&
                   (px >= x_lo) && (px < x_lo + DIM) &&
                   (py >= y_lo) && (py < y_lo + DIM);
      // Inside the sprite the offset is below 32, so the difference of the
      // low five bits equals the true offset.
      dx = DrawX[4:0] - active_tbl[i].x[4:0];
      dy = DrawY[4:0] - active_tbl[i].y[4:0];
      addr_vec[i] = {active_tbl[i].kind, dy, dx};
    end
  end

  // Lowest slot index wins: scan downwards so the last assignment made is
  // the lowest hitting slot.
  logic        any_hit;
  logic [11:0] win_addr;

  always_comb begin
    any_hit  = 1'b0;
    win_addr = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        any_hit  = 1'b1;
        win_addr = addr_vec[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Pixel pipeline. bg is carried as {red, green, blue}.
  // ------------------------------------------------------------------
  logic        s1_hit, s1_blank;
  logic [11:0] s1_bg;
  logic        s2_hit, s2_blank;
  logic [11:0] s2_bg;

  // Stage 1: ROM address plus sideband aligned to it.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      s1_hit   <= 1'b0;
      s1_blank <= 1'b0;
      s1_bg    <= '0;
    end else begin
      rom_addr <= win_addr;
      s1_hit   <= any_hit;
      s1_blank <= blank;
      s1_bg    <= {bg_red, bg_green, bg_blue};
    end
  end

  // Stage 2: sideband waits while the synchronous ROM reads.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      s2_hit   <= 1'b0;
      s2_blank <= 1'b0;
      s2_bg    <= '0;
    end else begin
      s2_hit   <= s1_hit;
      s2_blank <= s1_blank;
      s2_bg    <= s1_bg;
    end
  end

  // Stage 3: blanking forces black; an opaque sprite texel overrides the
  // background; a transparent texel (index 0) or no hit shows background.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!s2_blank) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (s2_hit && (rom_q != 8'h00)) begin
      red   <= pal_red;
      green <= pal_green;
      blue  <= pal_blue;
    end else begin
      red   <= s2_bg[11:8];
      green <= s2_bg[7:4];
      blue  <= s2_bg[3:0];
    end
  end

endmodule

// File: doc/sprite_draw_ctrl.md
SPRITE_DRAW_CTRL -- requirements
Module: sprite_draw_ctrl

Interface
REQ-001 Parameter NSLOT, 4, number of sprite object slots; the slot index is 2 bits.
REQ-002 Parameter SPR_DIM, 32, sprite width and height in pixels.
REQ-003 vga_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 DrawX, DrawY  in  10 each  current pixel coordinate on 800x525 timing.
REQ-006 blank  in  1  1 = visible region, 0 = blanking.
REQ-007 bg_red, bg_green, bg_blue  in  4 each  background colour for the current pixel.
REQ-008 wr_en  in  1  single-cycle object write strobe.
REQ-009 wr_slot  in  2  target slot.
REQ-010 wr_x, wr_y  in  10 each  sprite top-left corner.
REQ-011 wr_type  in  2  sprite image select.
REQ-012 wr_valid  in  1  1 = slot drawn, 0 = slot disabled.
REQ-013 commit_pending  out  1  shadow table holds writes not yet committed.
REQ-014 rom_addr  out  12  sprite ROM address, equal to {type, row[4:0], col[4:0]}.
REQ-015 rom_q  in  8  palette index from the external synchronous ROM; index 0 = transparent.
REQ-016 pal_red, pal_green, pal_blue  in  4 each  external combinational palette output for rom_q.
REQ-017 red, green, blue  out  4 each  registered pixel colour.

Function
REQ-018 Two object tables SHALL exist: shadow and active, each NSLOT entries of {x, y, type, valid}.
REQ-019 When wr_en=1, shadow[wr_slot] SHALL load the wr_* fields at the rising edge, and commit_pending SHALL set to 1.
REQ-020 The commit cycle is the cycle in which DrawX=799 and DrawY=524 are sampled; in that cycle the whole active table SHALL load the shadow table and commit_pending SHALL clear.
REQ-021 For wr_en=1 in the commit cycle: the pre-write shadow contents are committed, the new write lands in shadow only, and commit_pending SHALL remain 1.
REQ-022 Hit test per slot, performed in 11-bit arithmetic with no wrap: valid=1, x <= DrawX < x+SPR_DIM, and y <= DrawY < y+SPR_DIM; sprites extending past the screen edge are clipped with no wrap.
REQ-023 When several slots hit, the lowest slot index SHALL win.
REQ-024 Stage 1 (edge N+1, inputs sampled at edge N): rom_addr <= {type, DrawY-y, DrawX-x} of the winning slot, or 0 if no slot hits; register hit, blank and bg_* alongside.
REQ-025 The ROM samples rom_addr at edge N+2, so rom_q and pal_* are valid in the cycle after edge N+2; hit, blank and bg_* SHALL be delayed a second stage to match.
REQ-026 Stage 3 (edge N+3) output rule:
  - blank_d=0: red/green/blue <= 0.
  - otherwise hit_d=1 and rom_q!=0: red/green/blue <= pal_*.
  - otherwise: red/green/blue <= bg_* delayed.
REQ-027 Total latency from pixel coordinate to colour SHALL be exactly 3 cycles, independent of hits.
REQ-028 Writes SHALL never affect the current frame; the active table changes only at the commit cycle.

Reset
REQ-029 While Reset=1, both tables SHALL clear to 0 (all slots invalid), commit_pending=0, rom_addr=0, red/green/blue=0, and all pipeline registers=0.
REQ-030 Reset asserted mid-frame SHALL discard pending shadow writes; after release, output resumes with latency per REQ-027 and only background or black is shown.

Verification
REQ-031 Slot 0 {x=100, y=50, type=1, valid=1} written then committed; next frame pixel (110,60) -> rom_addr=0x54A one cycle later, and red/green/blue = pal_* three cycles later when rom_q!=0.
REQ-032 Slots 0 and 2 overlapping at (200,200) with types 1 and 3 -> rom_addr type bits = 1 (slot 0 wins).
REQ-033 rom_q=0 inside a sprite with bg=(4'h3,4'h5,4'h7) -> output 3/5/7; blank=0 -> output 0/0/0.
REQ-034 Write issued mid-frame -> commit_pending=1 and the frame is unchanged; commit cycle -> pending=0 and the new sprite appears from the next frame. A write in the commit cycle itself -> pending stays 1 and the sprite appears one frame later.
REQ-035 Slot at x=1000 -> DrawX 0..31 shows no hit (no wrap); x=630 -> columns 630..639 hit.
REQ-036 Reset pulse mid-frame after commit -> all outputs 0 during reset; after release, the previously visible sprite is absent.
